// File: rtl/assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : assoc_pkg
// Brief    : FSM state encoding and width helpers for assoc_seq_search.
// Revision : 1.0 - initial release
// ============================================================================
package assoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction

  // Like clog2 but never below 1, so a degenerate count still yields a legal vector.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// ============================================================================
// Module   : popcount_chunk
// Brief    : Combinational population count of one CHUNK_W-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_chunk
  import assoc_pkg::*;
#(
  parameter  int CHUNK_W = 64,
  localparam int CNT_W   = clog2w(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] data,
  output logic [CNT_W-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/assoc_seq_search.sv
`default_nettype none
// ============================================================================
// Module   : assoc_seq_search
// Brief    : Sequential associative search: best AND-popcount match of a query
//            against N_CLASS stored hypervectors, one chunk per cycle.
//            Optional macro ASSOC_THRESHOLD_EN adds thresh input / res_hit output.
// Revision : 1.0 - initial release
// ============================================================================
module assoc_seq_search
  import assoc_pkg::*;
#(
  parameter  int HV_W    = 1024,
  parameter  int N_CLASS = 26,
  parameter  int CHUNK_W = 64,
  localparam int N_CHUNK = HV_W / CHUNK_W,
  localparam int IDX_W   = clog2w(N_CLASS),
  localparam int CIDX_W  = clog2w(N_CHUNK),
  localparam int SCORE_W = clog2w(HV_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_class,
  input  logic [CIDX_W-1:0]  wr_chunk,
  input  logic [CHUNK_W-1:0] wr_data,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [HV_W-1:0]    q_hv,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDX_W-1:0]   res_class,
  output logic [SCORE_W-1:0] res_score,
`ifdef ASSOC_THRESHOLD_EN
  input  logic [SCORE_W-1:0] thresh,
  output logic               res_hit,
`endif
  output logic               busy
);

  localparam int DEPTH  = N_CLASS * N_CHUNK;
  localparam int ADDR_W = clog2w(DEPTH);
  localparam int PC_W   = clog2w(CHUNK_W + 1);
  localparam logic [IDX_W-1:0]  LAST_CLASS = IDX_W'(N_CLASS - 1);
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(N_CHUNK - 1);

  state_e                          r_state;
  logic                            r_alive;
  logic [N_CHUNK-1:0][CHUNK_W-1:0] r_query;
  logic [IDX_W-1:0]                r_class;
  logic [CIDX_W-1:0]               r_chunk;
  logic                            r_issue_done;
  logic [PC_W-1:0]                 r_pc;
  logic                            r_pc_vld;
  logic                            r_pc_last;
  logic                            r_pc_final;
  logic [IDX_W-1:0]                r_pc_class;
  logic [SCORE_W-1:0]              r_acc;
  logic [SCORE_W-1:0]              r_best_score;
  logic [IDX_W-1:0]                r_best_class;
  logic [CHUNK_W-1:0]              r_mem [DEPTH];
`ifdef ASSOC_THRESHOLD_EN
  logic [SCORE_W-1:0]              r_thresh;
`endif

  logic               w_accept;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic               w_wr_ok;
  logic [CHUNK_W-1:0] w_and;
  logic [PC_W-1:0]    w_pc;
  logic [SCORE_W-1:0] w_class_score;
  logic               w_take;

  assign q_ready   = (r_state == ST_IDLE) && r_alive;
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign res_class = r_best_class;
  assign res_score = r_best_score;
`ifdef ASSOC_THRESHOLD_EN
  assign res_hit   = res_valid && (r_best_score >= r_thresh);
`endif

  assign w_accept  = q_valid && q_ready;
  assign w_issue   = (r_state == ST_RUN) && !r_issue_done;
  assign w_rd_addr = ADDR_W'(r_class) * ADDR_W'(N_CHUNK) + ADDR_W'(r_chunk);
  assign w_wr_addr = ADDR_W'(wr_class) * ADDR_W'(N_CHUNK) + ADDR_W'(wr_chunk);
  assign w_wr_ok   = wr_en && (r_state == ST_IDLE) &&
                     (wr_class <= LAST_CLASS) && (wr_chunk <= LAST_CHUNK);
  assign w_and     = r_mem[w_rd_addr] & r_query[r_chunk];

  popcount_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_popcount (
    .data  (w_and),
    .count (w_pc)
  );

  // The chunk count is registered one stage ahead of the accumulator, which
  // accounts for the single extra cycle between the last read and res_valid.
  assign w_class_score = r_acc + SCORE_W'(r_pc);
  assign w_take        = (r_pc_class == '0) || (w_class_score > r_best_score);

  // Class memory is deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_alive      <= 1'b0;
      r_query      <= '0;
      r_class      <= '0;
      r_chunk      <= '0;
      r_issue_done <= 1'b0;
      r_pc         <= '0;
      r_pc_vld     <= 1'b0;
      r_pc_last    <= 1'b0;
      r_pc_final   <= 1'b0;
      r_pc_class   <= '0;
      r_acc        <= '0;
      r_best_score <= '0;
      r_best_class <= '0;
`ifdef ASSOC_THRESHOLD_EN
      r_thresh     <= '0;
`endif
    end else begin
      r_alive    <= 1'b1;
      r_pc       <= w_pc;
      r_pc_vld   <= w_issue;
      r_pc_last  <= (r_chunk == LAST_CHUNK);
      r_pc_final <= (r_chunk == LAST_CHUNK) && (r_class == LAST_CLASS);
      r_pc_class <= r_class;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_query      <= q_hv;
            r_class      <= '0;
            r_chunk      <= '0;
            r_issue_done <= 1'b0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_class <= '0;
`ifdef ASSOC_THRESHOLD_EN
            r_thresh     <= thresh;
`endif
            r_state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_issue) begin
            if (r_chunk == LAST_CHUNK) begin
              r_chunk <= '0;
              if (r_class == LAST_CLASS) begin
                r_issue_done <= 1'b1;
              end else begin
                r_class <= r_class + 1'b1;
              end
            end else begin
              r_chunk <= r_chunk + 1'b1;
            end
          end

          if (r_pc_vld) begin
            if (r_pc_last) begin
              r_acc <= '0;
              if (w_take) begin
                r_best_score <= w_class_score;
                r_best_class <= r_pc_class;
              end
              if (r_pc_final) begin
                r_state <= ST_DONE;
              end
            end else begin
              r_acc <= w_class_score;
            end
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
